// File: rtl/hsv_to_rgb.sv
// HSV to RGB colour converter for the PWM LED drivers.
// Fixed-latency pipeline: one sample per clock, result three edges after capture.
module hsv_to_rgb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] hue,
    input  logic [WIDTH-1:0] sat,
    input  logic [WIDTH-1:0] value,
    output logic             out_valid,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam int HW = WIDTH + 3;
    localparam int PW = 2 * WIDTH;

    // ---------------- Stage 1: hue scaling ----------------
    logic             v1_reg;
    logic [HW-1:0]    h6_reg;
    logic [WIDTH-1:0] sat1_reg;
    logic [WIDTH-1:0] val1_reg;
    logic             zero1_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_reg    <= 1'b0;
            h6_reg    <= '0;
            sat1_reg  <= '0;
            val1_reg  <= '0;
            zero1_reg <= 1'b0;
        end else begin
            v1_reg <= in_valid;
            if (in_valid) begin
                h6_reg    <= {3'b000, hue} * HW'(6);
                sat1_reg  <= sat;
                val1_reg  <= value;
                zero1_reg <= (sat == '0);
            end
        end
    end

    // ---------------- Stage 2: saturation terms ----------------
    logic [WIDTH-1:0] f1;
    logic [WIDTH-1:0] fc1;
    logic [2:0]       sec1;

    assign sec1 = h6_reg[HW-1:WIDTH];
    assign f1   = h6_reg[WIDTH-1:0];
    assign fc1  = MAX - f1;

    logic             v2_reg;
    logic [PW-1:0]    sf_reg;
    logic [PW-1:0]    sfc_reg;
    logic [WIDTH-1:0] nsat_reg;
    logic [WIDTH-1:0] val2_reg;
    logic [2:0]       sec2_reg;
    logic             zero2_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            v2_reg    <= 1'b0;
            sf_reg    <= '0;
            sfc_reg   <= '0;
            nsat_reg  <= '0;
            val2_reg  <= '0;
            sec2_reg  <= '0;
            zero2_reg <= 1'b0;
        end else begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                sf_reg    <= {{WIDTH{1'b0}}, sat1_reg} * {{WIDTH{1'b0}}, f1};
                sfc_reg   <= {{WIDTH{1'b0}}, sat1_reg} * {{WIDTH{1'b0}}, fc1};
                nsat_reg  <= MAX - sat1_reg;
                val2_reg  <= val1_reg;
                sec2_reg  <= sec1;
                zero2_reg <= zero1_reg;
            end
        end
    end

    // ---------------- Stage 3: value products ----------------
    logic [WIDTH-1:0] qf2;
    logic [WIDTH-1:0] tf2;
    logic [PW-1:0]    p_prod;
    logic [PW-1:0]    q_prod;
    logic [PW-1:0]    t_prod;

    assign qf2    = MAX - sf_reg[PW-1:WIDTH];
    assign tf2    = MAX - sfc_reg[PW-1:WIDTH];
    assign p_prod = {{WIDTH{1'b0}}, val2_reg} * {{WIDTH{1'b0}}, nsat_reg};
    assign q_prod = {{WIDTH{1'b0}}, val2_reg} * {{WIDTH{1'b0}}, qf2};
    assign t_prod = {{WIDTH{1'b0}}, val2_reg} * {{WIDTH{1'b0}}, tf2};

    logic             v3_reg;
    logic [WIDTH-1:0] p_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] t_reg;
    logic [WIDTH-1:0] val3_reg;
    logic [2:0]       sec3_reg;
    logic             zero3_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            v3_reg    <= 1'b0;
            p_reg     <= '0;
            q_reg     <= '0;
            t_reg     <= '0;
            val3_reg  <= '0;
            sec3_reg  <= '0;
            zero3_reg <= 1'b0;
        end else begin
            v3_reg <= v2_reg;
            if (v2_reg) begin
                p_reg     <= p_prod[PW-1:WIDTH];
                q_reg     <= q_prod[PW-1:WIDTH];
                t_reg     <= t_prod[PW-1:WIDTH];
                val3_reg  <= val2_reg;
                sec3_reg  <= sec2_reg;
                zero3_reg <= zero2_reg;
            end
        end
    end

    // ---------------- Sector select and output register ----------------
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] g_next;
    logic [WIDTH-1:0] b_next;

    always_comb begin
        r_next = val3_reg;
        g_next = val3_reg;
        b_next = val3_reg;
        case (sec3_reg)
            3'd0: begin r_next = val3_reg; g_next = t_reg;    b_next = p_reg;    end
            3'd1: begin r_next = q_reg;    g_next = val3_reg; b_next = p_reg;    end
            3'd2: begin r_next = p_reg;    g_next = val3_reg; b_next = t_reg;    end
            3'd3: begin r_next = p_reg;    g_next = q_reg;    b_next = val3_reg; end
            3'd4: begin r_next = t_reg;    g_next = p_reg;    b_next = val3_reg; end
            3'd5: begin r_next = val3_reg; g_next = p_reg;    b_next = q_reg;    end
            default: ;
        endcase
        // Grey override wins over the sector result so sat==0 is exact.
        if (zero3_reg) begin
            r_next = val3_reg;
            g_next = val3_reg;
            b_next = val3_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            r         <= '0;
            g         <= '0;
            b         <= '0;
        end else begin
            out_valid <= v3_reg;
            if (v3_reg) begin
                r <= r_next;
                g <= g_next;
                b <= b_next;
            end
        end
    end

endmodule
